sequential_divider_ct: RTL and testbench
========================================

# sequential_divider_ct

Constant-time sequential restoring divider that performs the inverse operation of the team's constant-time sequential multiplier. It accepts an unsigned dividend and divisor on `start` and runs exactly WIDTH iterations regardless of operand values, so the run time leaks nothing about the operands. It then presents the quotient and remainder with a done strobe. It sits beside the multiplier in the modular-arithmetic datapath and uses the same start/done handshake style.

## Interface
- `WIDTH`, default 2048: operand, quotient and remainder width in bits.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a division; sampled only in IDLE.
- `dividend`  input  WIDTH  unsigned dividend; captured on the accepting edge.
- `divisor`  input  WIDTH  unsigned divisor; captured on the accepting edge.
- `quotient`  output  WIDTH  registered quotient; reset value 0.
- `remainder`  output  WIDTH  registered remainder; reset value 0.
- `busy`  output  1  high in ITER and DONE; reset value 0.
- `quotientDone`  output  1  one-cycle strobe: results are valid; reset value 0.
- `divByZero`  output  1  captured divisor was 0; valid with `quotientDone`; reset value 0.

## Operation
- States: IDLE, ITER, DONE. Reset state is IDLE.
- IDLE:
  - With `start`=1 at a clock edge, capture the dividend into the Q register and the divisor into the D register.
  - Clear the (WIDTH+1)-bit partial remainder R and the iteration counter. Go to ITER.
- ITER: one restoring step per cycle.
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - Q <<= 1.
  - T = R' − {1'b0, D}, computed in WIDTH+1 bits.
  - If T[WIDTH]=0, then R = T and Q[0] = 1. Otherwise R = R' and Q[0] = 0.
  - The subtract is computed every cycle and its result is muxed in. No data-dependent skip or early exit is allowed.
  - The counter increments each step. After step WIDTH, go to DONE.
- DONE:
  - Drive `quotient` = Q and `remainder` = R[WIDTH-1:0]; both registered.
  - `quotientDone` = 1. Next edge goes to IDLE.
  - `quotient` and `remainder` hold their values until the next accepted `start` completes.
- `start` is ignored in ITER and DONE. There is no queuing.
- Divisor 0: the iteration runs unchanged and yields quotient = all ones and remainder = dividend, with the same latency as any other divide.
- Asserting `rst` low at any time immediately returns the block to IDLE and clears all outputs and internal registers. An in-flight result is discarded.

## Timing
- Accepting edge E0: `busy` goes high after E0.
- Steps occur on edges E1..EWIDTH. After EWIDTH the state is DONE and `quotientDone`=1 for exactly one cycle.
- After EWIDTH+1, `busy`=0 and `quotientDone`=0.
- Total latency is start edge to done = WIDTH cycles. Throughput is one divide per WIDTH+2 cycles.
- A `start` held high through DONE is accepted on the first IDLE edge after DONE, never earlier.
- Latency is identical for every operand pair, including divisor 0 and dividend 0.

## Configuration
- `DIVIDER_DBZ_FLAG_EN` defined: `divByZero` is registered as (divisor == 0) at the accepting edge, held until the next accept, and cleared by reset.
- `DIVIDER_DBZ_FLAG_EN` undefined: `divByZero` is tied to 0 and the comparator is not built.
- In both cases the quotient, remainder and timing are unchanged.

## Test plan
All scenarios use WIDTH=8.
- 200 / 7, `start` pulsed one cycle -> `quotientDone` exactly 8 cycles after the accepting edge, `quotient`=28, `remainder`=4, `divByZero`=0, `busy` high for 9 cycles.
- 255 / 1, then 5 / 9 back-to-back (start held high) -> 255 r 0, then 0 r 5. The second accept happens on the first IDLE edge, and both have identical latency.
- 100 / 0 -> `quotient`=255, `remainder`=100 after 8 cycles. `divByZero`=1 with the macro defined and 0 without it.
- `start` pulsed during ITER with different operands -> ignored; the original result is produced and there is no second `quotientDone`.
- `rst` driven low mid-ITER (step 4 of 200 / 7) -> all outputs 0 immediately and the state is IDLE. A new 50 / 6 completes as 8 r 2 with normal latency.
- Random sweep of 1000 operand pairs, including divisor 0 -> the results match `/` and `%` against a reference model (divisor 0: all ones, dividend), and every run has done latency exactly 8.

Source files
------------

// File: rtl/sequential_divider_ct.sv
// rtl/sequential_divider_ct.sv - constant-time sequential restoring divider
//
// Purpose:
//   Unsigned restoring divider that always takes exactly WIDTH iteration
//   cycles, independent of the operand values. Companion of the constant-time
//   sequential multiplier and uses the same start/done handshake.
//
// Optional feature:
//   DIVIDER_DBZ_FLAG_EN - when defined, divByZero is registered as
//   (divisor == 0) on the accepting edge. When undefined, divByZero is tied
//   low and no zero comparator is built.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-low reset
//   start        in   1      request a division (only looked at in IDLE)
//   dividend     in   WIDTH  unsigned dividend, captured on accept
//   divisor      in   WIDTH  unsigned divisor, captured on accept
//   quotient     out  WIDTH  registered quotient, held until the next result
//   remainder    out  WIDTH  registered remainder, held until the next result
//   busy         out  1      high while iterating and in the done cycle
//   quotientDone out  1      one-cycle strobe, results valid
//   divByZero    out  1      captured divisor was zero (optional feature)
//
// WIDTH must be at least 2.

module sequential_divider_ct #(
  parameter int WIDTH = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             quotientDone,
  output logic             divByZero
);

  // Counter runs 0..WIDTH-1, one value per restoring step.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Control strobes decoded from the FSM.
  logic accept;
  logic step;
  logic last_step;

  // Working registers.
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    cnt;

  // Output registers.
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;

  // One restoring step, evaluated every cycle.
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             trial_neg;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_step;

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next-state and control decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ITER;
        end
      end
      ITER: begin
        // The iteration count is fixed; there is no early exit on any
        // operand value, so timing carries no information about the data.
        step = 1'b1;
        if (cnt == LAST_STEP) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // start is deliberately ignored here; a held start is taken on the
        // following IDLE edge.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Restoring step datapath
  // ---------------------------------------------------------------------
  // The partial remainder is conceptually WIDTH+1 bits, but after every
  // restoring step it is either below the divisor or (divisor 0) holds at
  // most the number of dividend bits shifted in so far. Its top bit is
  // therefore always zero at the register boundary, so only the shift and
  // subtract path carries the extra bit.
  always_comb begin
    r_shift   = {r_reg, q_reg[WIDTH-1]};
    trial     = r_shift - {1'b0, d_reg};
    trial_neg = trial[WIDTH];
    // Subtract result is always computed and only selected by the mux.
    q_step    = {q_reg[WIDTH-2:0], ~trial_neg};
    r_step    = trial_neg ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= '0;
      d_reg <= '0;
      r_reg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      q_reg <= dividend;
      d_reg <= divisor;
      r_reg <= '0;
      cnt   <= '0;
    end else if (step) begin
      q_reg <= q_step;
      r_reg <= r_step;
      cnt   <= cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Result registers: loaded on the final step edge so they are valid in
  // the DONE cycle, then held until the next division completes.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else if (last_step) begin
      quotient_reg  <= q_step;
      remainder_reg <= r_step;
    end
  end

  assign quotient     = quotient_reg;
  assign remainder    = remainder_reg;
  assign busy         = (state != IDLE);
  assign quotientDone = (state == DONE);

  // ---------------------------------------------------------------------
  // Optional divide-by-zero flag
  // ---------------------------------------------------------------------
`ifdef DIVIDER_DBZ_FLAG_EN
  logic dbz_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbz_reg <= 1'b0;
    end else if (accept) begin
      dbz_reg <= (divisor == '0);
    end
  end

  assign divByZero = dbz_reg;
`else
  assign divByZero = 1'b0;
`endif

endmodule

// File: tb/tb_sequential_divider_ct.sv
// tb/tb_sequential_divider_ct.sv - self-checking bench for sequential_divider_ct

module tb_sequential_divider_ct;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         quotientDone;
  logic         divByZero;

  int checks;
  int errors;

  sequential_divider_ct #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dividend     (dividend),
    .divisor      (divisor),
    .quotient     (quotient),
    .remainder    (remainder),
    .busy         (busy),
    .quotientDone (quotientDone),
    .divByZero    (divByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic, with the divisor-0 convention.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eq, output logic [W-1:0] er,
                         output logic edbz);
    if (b == 0) begin
      eq = {W{1'b1}};
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
`ifdef DIVIDER_DBZ_FLAG_EN
    edbz = (b == 0);
`else
    edbz = 1'b0;
`endif
  endtask

  // Launch one division from IDLE and check result, latency and busy span.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold, input bit glitch, input string tag);
    int lat;
    int bcnt;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic edbz;
    ref_div(a, b, eq, er, edbz);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    bcnt = busy ? 1 : 0;
    lat  = 0;
    while (!quotientDone && lat < 40) begin
      if (glitch && lat == 3) begin
        start    = 1'b1;
        dividend = 8'd13;
        divisor  = 8'd3;
      end else if (glitch && lat == 4) begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (busy) bcnt++;
    end
    check({tag, "/latency"}, lat, W);
    check({tag, "/quotient"}, quotient, eq);
    check({tag, "/remainder"}, remainder, er);
    check({tag, "/divByZero"}, divByZero, edbz);
    check({tag, "/busy_cycles"}, bcnt, W + 1);
    tick();
    check({tag, "/busy_after"}, busy, 1'b0);
    check({tag, "/done_after"}, quotientDone, 1'b0);
    check({tag, "/quotient_held"}, quotient, eq);
  endtask

  initial begin
    int extra_done;
    logic [W-1:0] a;
    logic [W-1:0] b;
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("reset/quotient", quotient, 0);
    check("reset/remainder", remainder, 0);
    check("reset/busy", busy, 0);
    check("reset/done", quotientDone, 0);
    check("reset/dbz", divByZero, 0);
    #2 rst = 1'b1;
    tick();

    // Basic divide with a one-cycle start pulse.
    run_div(8'd200, 8'd7, 1'b0, 1'b0, "d200_7");

    // Back-to-back with start held: second accept only on the first IDLE edge.
    run_div(8'd255, 8'd1, 1'b1, 1'b0, "d255_1");
    run_div(8'd5, 8'd9, 1'b0, 1'b0, "d5_9");
    tick();

    // Divisor zero.
    run_div(8'd100, 8'd0, 1'b0, 1'b0, "d100_0");
    tick();

    // start during ITER is ignored and produces no second done.
    run_div(8'd200, 8'd7, 1'b0, 1'b1, "glitch");
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (quotientDone) extra_done++;
    end
    check("glitch/no_second_done", extra_done, 0);

    // Asynchronous reset in the middle of an iteration.
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b0;
    #1;
    check("midreset/quotient", quotient, 0);
    check("midreset/remainder", remainder, 0);
    check("midreset/busy", busy, 0);
    check("midreset/done", quotientDone, 0);
    check("midreset/dbz", divByZero, 0);
    #1 rst = 1'b1;
    run_div(8'd50, 8'd6, 1'b0, 1'b0, "d50_6");

    // Random sweep, divisor 0 and dividend 0 mixed in.
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 15) == 0) a = '0;
      run_div(a, b, 1'b0, 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
